// File: rtl/axis_packet_source.sv
// AXI4-Stream packet generator: N packets of L beats, incrementing (or LFSR with AXIS_PKT_SOURCE_LFSR_EN) data,
// programmable idle gap. Valid one cycle after start; stalls on !output_tready hold all beat state.
module axis_packet_source #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [15:0]           num_pkts,
  input  logic [7:0]            gap,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic [DATA_WIDTH-1:0] output_tdata,
  output logic                  output_tvalid,
  input  logic                  output_tready,
  output logic                  output_tlast,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           pkts_sent
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t                state, state_nxt;
  logic [LEN_WIDTH-1:0]  len_q, beat_cnt;
  logic [15:0]           num_q, pkts_sent_q;
  logic [7:0]            gap_q, gap_cnt;
  logic [DATA_WIDTH-1:0] data_q, data_nxt, seed_eff;
  logic                  done_q;
  logic                  start_ok, xfer, last_beat, last_pkt;

`ifdef AXIS_PKT_SOURCE_LFSR_EN
  generate
    if (DATA_WIDTH != 8) begin : g_width_check
      $error("axis_packet_source: LFSR pattern requires DATA_WIDTH == 8");
    end
  endgenerate

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1; the all-zero state would lock up
  assign data_nxt = {data_q[6:0], data_q[7] ^ data_q[5] ^ data_q[4] ^ data_q[3]};
  assign seed_eff = (seed == '0) ? DATA_WIDTH'(1) : seed;
`else
  assign data_nxt = data_q + DATA_WIDTH'(1);
  assign seed_eff = seed;
`endif

  assign start_ok  = (state == IDLE) && start && (pkt_len != '0) && (num_pkts != '0);
  assign xfer      = output_tvalid && output_tready;
  assign last_beat = (beat_cnt == len_q - LEN_WIDTH'(1));
  assign last_pkt  = (pkts_sent_q == num_q - 16'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_ok) state_nxt = SEND;
      SEND: begin
        if (xfer && last_beat) begin
          if (last_pkt)          state_nxt = IDLE;
          else if (gap_q != '0)  state_nxt = GAP;
          else                   state_nxt = SEND;
        end
      end
      GAP:  if (gap_cnt == '0) state_nxt = SEND;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    output_tvalid = (state == SEND);
    output_tlast  = (state == SEND) && last_beat;
    busy          = (state != IDLE);
    output_tdata  = data_q;
    done          = done_q;
    pkts_sent     = pkts_sent_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q       <= '0;
      num_q       <= '0;
      gap_q       <= '0;
      gap_cnt     <= '0;
      beat_cnt    <= '0;
      pkts_sent_q <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_ok) begin
        len_q       <= pkt_len;
        num_q       <= num_pkts;
        gap_q       <= gap;
        data_q      <= seed_eff;
        beat_cnt    <= '0;
        pkts_sent_q <= '0;
      end
      if (xfer) begin
        data_q <= data_nxt;
        if (last_beat) begin
          beat_cnt    <= '0;
          pkts_sent_q <= pkts_sent_q + 16'd1;
          done_q      <= last_pkt;
          // GAP runs while gap_cnt counts G-1 down to 0, giving G idle cycles
          gap_cnt     <= gap_q - 8'd1;
        end else begin
          beat_cnt <= beat_cnt + LEN_WIDTH'(1);
        end
      end
      if (state == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_axis_packet_source.sv
// Directed bench for axis_packet_source with a beat-queue reference model checked every cycle.
module tb_axis_packet_source;

  localparam int DW = 8;
  localparam int LW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [LW-1:0] pkt_len;
  logic [15:0]   num_pkts;
  logic [7:0]    gap;
  logic [DW-1:0] seed;
  logic [DW-1:0] output_tdata;
  logic          output_tvalid;
  logic          output_tready;
  logic          output_tlast;
  logic          busy;
  logic          done;
  logic [15:0]   pkts_sent;

  axis_packet_source #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .pkt_len(pkt_len), .num_pkts(num_pkts),
    .gap(gap), .seed(seed), .output_tdata(output_tdata), .output_tvalid(output_tvalid),
    .output_tready(output_tready), .output_tlast(output_tlast), .busy(busy), .done(done),
    .pkts_sent(pkts_sent)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: every beat the job still owes, in order
  logic [DW-1:0] exp_d[$];
  bit            exp_l[$];
  int            exp_pkts, gap_left, cyc;
  bit            done_next, stall_pend, hold_l;
  logic [DW-1:0] hold_d;
  bit            job_pend;
  int            job_seed, job_len, job_num, job_gap;
  int            done_cnt;
  logic [DW-1:0] log_d[$];
  bit            log_l[$];
  int            log_c[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_cycle();
    bit exp_valid, d_exp;
    exp_valid = (exp_d.size() != 0) && (gap_left == 0);
    d_exp     = done_next;
    done_next = 1'b0;
    chk("valid", {31'd0, output_tvalid}, {31'd0, exp_valid});
    chk("busy", {31'd0, busy}, {31'd0, exp_d.size() != 0});
    chk("done", {31'd0, done}, {31'd0, d_exp});
    chk("pkts_sent", {16'd0, pkts_sent}, exp_pkts);
    if (done) done_cnt++;
    if (stall_pend) begin
      chk("stall_data", {24'd0, output_tdata}, {24'd0, hold_d});
      chk("stall_last", {31'd0, output_tlast}, {31'd0, hold_l});
    end
    if (output_tvalid && exp_valid) begin
      chk("data", {24'd0, output_tdata}, {24'd0, exp_d[0]});
      chk("last", {31'd0, output_tlast}, {31'd0, exp_l[0]});
      if (output_tready && !reset) begin
        log_d.push_back(exp_d[0]);
        log_l.push_back(exp_l[0]);
        log_c.push_back(cyc);
        void'(exp_d.pop_front());
        if (exp_l.pop_front()) begin
          exp_pkts++;
          if (exp_d.size() == 0) done_next = 1'b1;
          else                   gap_left  = job_gap;
        end
      end
    end else if (gap_left > 0 && exp_d.size() != 0) begin
      gap_left--;
    end
    stall_pend = output_tvalid && !output_tready && !reset;
    hold_d     = output_tdata;
    hold_l     = output_tlast;
    if (reset) begin
      exp_d.delete();
      exp_l.delete();
      exp_pkts   = 0;
      done_next  = 1'b0;
      gap_left   = 0;
      stall_pend = 1'b0;
    end
    if (job_pend) begin
      for (int p = 0; p < job_num; p++)
        for (int b = 0; b < job_len; b++) begin
          exp_d.push_back(DW'(job_seed + p * job_len + b));
          exp_l.push_back(b == job_len - 1);
        end
      exp_pkts = 0;
      gap_left = 0;
      job_pend = 1'b0;
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_d.delete();
    log_l.delete();
    log_c.delete();
    done_cnt = 0;
  endtask

  // valid=1 marks a command the model expects to be accepted
  task automatic issue(input int s, input int l, input int n, input int g, input bit valid);
    seed     = DW'(s);
    pkt_len  = LW'(l);
    num_pkts = 16'(n);
    gap      = 8'(g);
    start    = 1'b1;
    if (valid) begin
      job_seed = s; job_len = l; job_num = n; job_gap = g;
      job_pend = 1'b1;
    end
    tick();
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      tick();
      if (exp_d.size() == 0 && !job_pend) break;
    end
    if (k == budget) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: %0d beats still owed after %0d cycles", exp_d.size(), budget);
    end
    tick();
  endtask

  initial begin
    exp_pkts = 0; gap_left = 0; cyc = 0; done_next = 0; stall_pend = 0;
    hold_d = '0; hold_l = 0; job_pend = 0; done_cnt = 0;
    job_seed = 0; job_len = 0; job_num = 0; job_gap = 0;
    reset = 1'b1; start = 1'b0; pkt_len = '0; num_pkts = '0; gap = '0; seed = '0;
    output_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, output_tvalid}, 32'd0);
    chk("rst_last", {31'd0, output_tlast}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pkts", {16'd0, pkts_sent}, 32'd0);
    chk("rst_data", {24'd0, output_tdata}, 32'd0);
    reset = 1'b0;
    tick();

    // basic
    clear_log();
    issue(8'hAA, 4, 1, 0, 1);
    drain(50);
    chk("basic_n", log_d.size(), 4);
    if (log_d.size() == 4) begin
      chk("basic_d0", {24'd0, log_d[0]}, 32'hAA);
      chk("basic_d3", {24'd0, log_d[3]}, 32'hAD);
      chk("basic_l2", {31'd0, log_l[2]}, 32'd0);
      chk("basic_l3", {31'd0, log_l[3]}, 32'd1);
      chk("basic_span", log_c[3] - log_c[0], 3);
    end
    chk("basic_pkts", {16'd0, pkts_sent}, 32'd1);
    chk("basic_done_cnt", done_cnt, 1);

    // gap and wrap
    clear_log();
    issue(8'hFE, 3, 2, 2, 1);
    drain(50);
    chk("gap_n", log_d.size(), 6);
    if (log_d.size() == 6) begin
      chk("gap_d2", {24'd0, log_d[2]}, 32'h00);
      chk("gap_d3", {24'd0, log_d[3]}, 32'h01);
      chk("gap_d5", {24'd0, log_d[5]}, 32'h03);
      chk("gap_l2", {31'd0, log_l[2]}, 32'd1);
      chk("gap_idle", log_c[3] - log_c[2], 3);
    end
    chk("gap_pkts", {16'd0, pkts_sent}, 32'd2);

    // backpressure, ready toggling every cycle
    clear_log();
    issue(8'h00, 8, 1, 0, 1);
    for (int k = 0; k < 100 && exp_d.size() != 0; k++) begin
      output_tready = ~output_tready;
      tick();
    end
    output_tready = 1'b1;
    drain(10);
    chk("bp_n", log_d.size(), 8);
    for (int i = 0; i < log_d.size(); i++) chk("bp_data", {24'd0, log_d[i]}, i);

    // back-to-back, gap 0
    clear_log();
    issue(8'h10, 2048, 2, 0, 1);
    drain(5000);
    chk("b2b_n", log_d.size(), 4096);
    if (log_d.size() == 4096) begin
      chk("b2b_span", log_c[4095] - log_c[0], 4095);
      chk("b2b_l2047", {31'd0, log_l[2047]}, 32'd1);
      chk("b2b_l2048", {31'd0, log_l[2048]}, 32'd0);
      chk("b2b_l4095", {31'd0, log_l[4095]}, 32'd1);
    end

    // start while busy is ignored
    clear_log();
    issue(8'h30, 6, 1, 0, 1);
    tick();
    issue(8'h99, 2, 3, 0, 0);
    drain(50);
    chk("busy_start_n", log_d.size(), 6);
    if (log_d.size() == 6) chk("busy_start_d5", {24'd0, log_d[5]}, 32'h35);

    // zero-length start is ignored
    clear_log();
    issue(8'h40, 0, 1, 0, 0);
    repeat (4) tick();
    chk("zero_len_done", done_cnt, 0);
    chk("zero_len_busy", {31'd0, busy}, 32'd0);

    // reset mid-packet, then restart
    clear_log();
    issue(8'h50, 10, 1, 0, 1);
    for (int k = 0; k < 50 && log_d.size() < 5; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", {31'd0, output_tvalid}, 32'd0);
    chk("mid_rst_last", {31'd0, output_tlast}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_pkts", {16'd0, pkts_sent}, 32'd0);
    tick();
    clear_log();
    issue(8'h50, 2, 1, 0, 1);
    chk("restart_pkts", {16'd0, pkts_sent}, 32'd0);
    chk("restart_data", {24'd0, output_tdata}, 32'h50);
    drain(20);
    chk("restart_n", log_d.size(), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_packet_source.md
# axis_packet_source

- Parameterised AXI4-Stream packet transmitter: on a start command it emits N packets of L beats each, with a deterministic data pattern, `output_tlast` on the final beat of each packet and a programmable idle gap between packets.
- Sits upstream of the stream FIFO and drives its `input_t*` slave port.
- Serves as the traffic source for FIFO bring-up and throughput measurement.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: width of `output_tdata`.
- `LEN_WIDTH`, default 12: width of `pkt_len`; packet length is 1..2^LEN_WIDTH-1 beats.

Ports:
- `clk` input 1: single clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: command strobe; sampled only in IDLE.
- `pkt_len` input LEN_WIDTH: beats per packet; latched on accepted start.
- `num_pkts` input 16: packets to send; latched on accepted start.
- `gap` input 8: idle cycles between packets; latched on accepted start.
- `seed` input DATA_WIDTH: data value of the first beat; latched on accepted start.
- `output_tdata` output DATA_WIDTH: stream data.
- `output_tvalid` output 1: stream valid.
- `output_tready` input 1: downstream ready.
- `output_tlast` output 1: last beat of the packet.
- `busy` output 1: high whenever state is not IDLE.
- `done` output 1: one-cycle pulse after the final beat of the final packet is accepted.
- `pkts_sent` output 16: packets completed since the last accepted start.

## Operation
- **States:** IDLE, SEND, GAP.
- **Reset values:** all outputs 0, state IDLE.
- **IDLE:**
  - `start`=1 with `pkt_len`≠0 and `num_pkts`≠0: latch the inputs, clear `pkts_sent`, go to SEND.
  - `start` with a zero length or zero count: ignored; no `done`.
- **SEND:**
  - `output_tvalid`=1.
  - A beat transfers when `output_tvalid` && `output_tready`.
  - The beat counter increments only on transfer.
  - `output_tlast`=1 exactly when beat index = latched `pkt_len`-1.
- **On the tlast transfer:**
  - `pkts_sent` increments.
  - If it was the last packet: go to IDLE and pulse `done`.
  - Else if `gap`≠0: go to GAP.
  - Else: stay in SEND and begin the next packet at beat 0.
- **GAP:**
  - `output_tvalid`=0.
  - Count exactly `gap` cycles, then return to SEND.
- **AXI-S rules:**
  - Once `output_tvalid` rises, it holds until transfer.
  - `output_tdata` and `output_tlast` are stable while `output_tvalid` && !`output_tready`.
  - `output_tvalid` never depends combinationally on `output_tready`.
- **Data pattern:**
  - The first beat after an accepted start carries `seed`.
  - Each transfer advances the pattern to value+1, mod 2^DATA_WIDTH (wraps FF→00 at width 8).
  - The pattern continues across packet boundaries; it is not reset per packet.
- **Ignored inputs:** `start` while `busy` is ignored. Input changes after the latch have no effect.
- **Reset mid-operation:**
  - At the reset edge, `output_tvalid`, `output_tlast`, `busy`, `done` and `pkts_sent` go to 0 and the state goes to IDLE.
  - Dropping valid without a transfer is permitted only under reset.

## Timing
- **Start latency:** `start` sampled at edge N; `busy` and `output_tvalid` are high after edge N, carrying `seed`.
- **Throughput:** 1 beat/cycle with `output_tready` held high; back-to-back packets when `gap`=0.
- **Gap:** a tlast transfer at edge M with `gap`=G gives `output_tvalid` low for cycles M..M+G-1 and high again after edge M+G.
- **Completion:**
  - Final tlast transfer at edge M.
  - `done`=1 and `busy`=0 for the cycle following edge M.
  - `pkts_sent` = `num_pkts` from the same point.
  - `done` clears after edge M+1.
- **Earliest restart:** a new `start` can be accepted at edge M+1.
- **Backpressure:** stalls hold the beat counter, pattern and outputs with no loss or duplication. The total is exactly `pkt_len`×`num_pkts` transfers.

## Configuration
- **Macro:** `AXIS_PKT_SOURCE_LFSR_EN`.
- **Defined:**
  - The pattern is an 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, advanced once per transfer; the first beat is still `seed`.
  - A `seed` of 0 is replaced by 8'h01.
  - `DATA_WIDTH` must equal 8; otherwise this is an elaboration error.
- **Undefined:** the incrementing pattern.

## Test plan
- **Basic:** `pkt_len`=4, `num_pkts`=1, `seed`=8'hAA, `output_tready`=1 → beats AA, AB, AC, AD on consecutive cycles; tlast only on AD; `done` pulse next cycle; `pkts_sent`=1.
- **Gap and wrap:** `pkt_len`=3, `num_pkts`=2, `gap`=2, `seed`=8'hFE → FE, FF, 00(tlast), 2 idle cycles, 01, 02, 03(tlast); `pkts_sent` steps 1 then 2.
- **Backpressure:** `pkt_len`=8 with `output_tready` toggling 1010… → exactly 8 transfers 00..07; data and tlast stable during every stall; no valid drop.
- **Back-to-back:** `gap`=0, `pkt_len`=2048, `num_pkts`=2, the FIFO as sink and its output drained → 4096 contiguous beats; tlast at beats 2047 and 4095.
- **Ignored commands:**
  - `start` while busy → no effect on the packet in progress.
  - `start` with `pkt_len`=0 → stays IDLE with no `done`.
- **Reset mid-packet:** reset asserted after beat 5 of a 10-beat packet → all outputs 0 the next cycle. A following `start` resends from `seed` with `pkts_sent`=0.
